// File: rtl/mine_pkg.sv
// Shared encodings for the minesweeper game controller and its flood-fill helper.
package mine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MOVE   = 3'd1,
        ST_REVEAL = 3'd2,
        ST_FLOOD  = 3'd3,
        ST_WON    = 3'd4,
        ST_LOST   = 3'd5
    } mine_state_t;

    localparam logic [1:0] GAME_PLAY = 2'b00;
    localparam logic [1:0] GAME_WON  = 2'b01;
    localparam logic [1:0] GAME_LOST = 2'b10;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [3:0] STATE_BOMB = 4'd9;

endpackage

// File: rtl/mine_flood_step.sv
// One combinational pass of zero-cascade reveal: marks hidden non-bomb squares that
// touch an already revealed zero square. Index 0 is bottom-right, N-1 top-left.
module mine_flood_step #(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4
) (
    input  logic [GRID_SIZE*GRID_SIZE-1:0]            bombGrid,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]            revealGrid,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
    output logic [GRID_SIZE*GRID_SIZE-1:0]            expand
);

    localparam int N = GRID_SIZE * GRID_SIZE;

    // Neighbour set of a square, clipped at the grid edges (no wrap).
    function automatic logic [N-1:0] neighbour_mask(input int idx);
        logic [N-1:0] m;
        int r, c, rr, cc;
        m = '0;
        r = idx / GRID_SIZE;
        c = idx % GRID_SIZE;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < GRID_SIZE &&
                    cc >= 0 && cc < GRID_SIZE) begin
                    m[rr*GRID_SIZE + cc] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    logic [N-1:0] zero_revealed;

    for (genvar i = 0; i < N; i++) begin : g_cell
        localparam logic [N-1:0] NB_MASK = neighbour_mask(i);
        assign zero_revealed[i] = revealGrid[i] &
                                  (states[i*STATE_SIZE +: STATE_SIZE] == '0);
        assign expand[i] = ~bombGrid[i] & ~revealGrid[i] & (|(zero_revealed & NB_MASK));
    end

endmodule

// File: rtl/mine_controller.sv
// Minesweeper game controller: owns bomb/reveal/cursor registers, drives the board.
// Optional MINE_FIRST_CLICK_SAFE_EN: first reveal of a game never hits a bomb.
//
// state  | meaning
// IDLE   | waiting for a button, checks for a win every cycle
// MOVE   | move strobe out, latch board's proposed cursor next edge
// REVEAL | reveal square under cursor (extra cycle if first-click bomb removed)
// FLOOD  | one zero-cascade pass per cycle until nothing new expands
// WON    | terminal, only bombLoad/reset leave
// LOST   | terminal, only bombLoad/reset leave
module mine_controller
    import mine_pkg::*;
#(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       bombLoad,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]             bombIn,
    input  logic                                       btnMove,
    input  logic [1:0]                                 btnDir,
    input  logic                                       btnReveal,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0]  states,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]             nextCursorGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]             bombGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]             revealGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]             cursorGrid,
    output logic                                       move,
    output logic [1:0]                                 dir,
    output logic [1:0]                                 gameState,
    output logic                                       busy
);

    localparam int N = GRID_SIZE * GRID_SIZE;
    localparam logic [N-1:0] CURSOR_HOME = {1'b1, {(N-1){1'b0}}};

    mine_state_t  state_q, state_d;
    logic [N-1:0] bomb_q, bomb_d;
    logic [N-1:0] reveal_q, reveal_d;
    logic [N-1:0] cursor_q, cursor_d;
    logic         move_q, move_d;
    logic [1:0]   dir_q, dir_d;
    logic [N-1:0] expand;
    logic [N-1:0] state_zero;
    logic         cur_bomb, cur_revealed, cur_zero;
`ifdef MINE_FIRST_CLICK_SAFE_EN
    logic         first_q, first_d;
`endif

    mine_flood_step #(
        .GRID_SIZE  (GRID_SIZE),
        .STATE_SIZE (STATE_SIZE)
    ) u_flood_step (
        .bombGrid   (bomb_q),
        .revealGrid (reveal_q),
        .states     (states),
        .expand     (expand)
    );

    for (genvar i = 0; i < N; i++) begin : g_zero
        assign state_zero[i] = (states[i*STATE_SIZE +: STATE_SIZE] == '0);
    end

    assign cur_bomb     = |(cursor_q & bomb_q);
    assign cur_revealed = |(cursor_q & reveal_q);
    assign cur_zero     = |(cursor_q & state_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bomb_q   <= '0;
            reveal_q <= '0;
            cursor_q <= CURSOR_HOME;
            move_q   <= 1'b0;
            dir_q    <= DIR_RIGHT;
`ifdef MINE_FIRST_CLICK_SAFE_EN
            first_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            bomb_q   <= bomb_d;
            reveal_q <= reveal_d;
            cursor_q <= cursor_d;
            move_q   <= move_d;
            dir_q    <= dir_d;
`ifdef MINE_FIRST_CLICK_SAFE_EN
            first_q  <= first_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        bomb_d   = bomb_q;
        reveal_d = reveal_q;
        cursor_d = cursor_q;
        move_d   = 1'b0;
        dir_d    = dir_q;
`ifdef MINE_FIRST_CLICK_SAFE_EN
        first_d  = first_q;
`endif
        if (bombLoad) begin
            bomb_d   = bombIn;
            reveal_d = '0;
            cursor_d = CURSOR_HOME;
            state_d  = ST_IDLE;
`ifdef MINE_FIRST_CLICK_SAFE_EN
            first_d  = 1'b1;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if ((reveal_q | bomb_q) == '1) begin
                        state_d = ST_WON;
                    end else if (btnReveal) begin
                        state_d = ST_REVEAL;
                    end else if (btnMove) begin
                        dir_d   = btnDir;
                        move_d  = 1'b1;
                        state_d = ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    // Wall moves and board glitches show up as a non-one-hot proposal.
                    if ($onehot(nextCursorGrid)) cursor_d = nextCursorGrid;
                    state_d = ST_IDLE;
                end
                ST_REVEAL: begin
`ifdef MINE_FIRST_CLICK_SAFE_EN
                    first_d = 1'b0;
`endif
                    if (cur_revealed) begin
                        state_d = ST_IDLE;
`ifdef MINE_FIRST_CLICK_SAFE_EN
                    end else if (first_q && cur_bomb) begin
                        // Stay one more cycle so states[] reflects the removed bomb.
                        bomb_d = bomb_q & ~cursor_q;
`endif
                    end else if (cur_bomb) begin
                        reveal_d = reveal_q | bomb_q;
                        state_d  = ST_LOST;
                    end else begin
                        reveal_d = reveal_q | cursor_q;
                        state_d  = cur_zero ? ST_FLOOD : ST_IDLE;
                    end
                end
                ST_FLOOD: begin
                    reveal_d = reveal_q | expand;
                    if (expand == '0) state_d = ST_IDLE;
                end
                ST_WON, ST_LOST: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bombGrid   = bomb_q;
    assign revealGrid = reveal_q;
    assign cursorGrid = cursor_q;
    assign move       = move_q;
    assign dir        = dir_q;
    assign busy       = (state_q == ST_MOVE) || (state_q == ST_REVEAL) || (state_q == ST_FLOOD);
    assign gameState  = (state_q == ST_WON)  ? GAME_WON  :
                        (state_q == ST_LOST) ? GAME_LOST : GAME_PLAY;

endmodule

// File: tb/tb_mine_controller.sv
// Scoreboard bench for mine_controller on a 3x3 grid with a behavioural board model.
module tb_mine_controller;
    import mine_pkg::*;

    localparam int G = 3;
    localparam int S = 4;
    localparam int N = 9;

    logic         clk = 1'b0;
    logic         reset, bombLoad, btnMove, btnReveal;
    logic [N-1:0] bombIn;
    logic [1:0]   btnDir;
    logic [S*N-1:0] states;
    logic [N-1:0] nextCursorGrid, bombGrid, revealGrid, cursorGrid;
    logic         move, busy;
    logic [1:0]   dir, gameState;
    logic         force_bad = 1'b0;

    always #5 clk = ~clk;

    mine_controller #(.GRID_SIZE(G), .STATE_SIZE(S)) dut (
        .clk(clk), .reset(reset), .bombLoad(bombLoad), .bombIn(bombIn),
        .btnMove(btnMove), .btnDir(btnDir), .btnReveal(btnReveal),
        .states(states), .nextCursorGrid(nextCursorGrid),
        .bombGrid(bombGrid), .revealGrid(revealGrid), .cursorGrid(cursorGrid),
        .move(move), .dir(dir), .gameState(gameState), .busy(busy)
    );

    // Board model: adjacent-bomb counts and proposed cursor (0 when moving into a wall).
    function automatic logic [3:0] board_state(input logic [N-1:0] b, input int idx);
        int r, c, rr, cc, cnt;
        if (b[idx]) return STATE_BOMB;
        cnt = 0;
        r = idx / G;
        c = idx % G;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < G && cc >= 0 && cc < G)
                    if (b[rr*G + cc]) cnt++;
            end
        return 4'(cnt);
    endfunction

    always_comb begin
        states = '0;
        for (int i = 0; i < N; i++) states[i*S +: S] = board_state(bombGrid, i);
    end

    always_comb begin
        nextCursorGrid = '0;
        case (dir)
            DIR_RIGHT: nextCursorGrid = ((cursorGrid & 9'h049) != 0) ? 9'h000 : cursorGrid >> 1;
            DIR_LEFT:  nextCursorGrid = ((cursorGrid & 9'h124) != 0) ? 9'h000 : cursorGrid << 1;
            DIR_UP:    nextCursorGrid = ((cursorGrid & 9'h1C0) != 0) ? 9'h000 : cursorGrid << 3;
            DIR_DOWN:  nextCursorGrid = ((cursorGrid & 9'h007) != 0) ? 9'h000 : cursorGrid >> 3;
            default:   nextCursorGrid = '0;
        endcase
        if (force_bad) nextCursorGrid = 9'h003;
    end

    typedef struct packed {
        logic [N-1:0] bomb;
        logic [N-1:0] reveal;
        logic [N-1:0] cursor;
        logic [1:0]   game;
        logic         bsy;
        logic         mv;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    aux_act_q[$];
    int    aux_exp_q[$];
    string aux_name_q[$];
    logic  chk_req = 1'b0;

    int    tests = 0;
    int    fails = 0;
    int    move_width = 0;
    snap_t act_s, exp_s;
    string nm;
    int    aa, ae;

    // Monitor: drains side checks, compares snapshots on request, checks move pulse width.
    always @(negedge clk) begin
        while (aux_act_q.size() > 0) begin
            aa = aux_act_q.pop_front();
            ae = aux_exp_q.pop_front();
            nm = aux_name_q.pop_front();
            tests++;
            if (aa != ae) begin
                fails++;
                $display("FAIL %s: got %0d, want %0d", nm, aa, ae);
            end
        end
        if (chk_req) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: got no expectation, want one");
            end else begin
                exp_s = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_s = '{bombGrid, revealGrid, cursorGrid, gameState, busy, move};
                if (act_s !== exp_s) begin
                    fails++;
                    $display("FAIL %s: got bomb=%h reveal=%h cursor=%h game=%b busy=%b move=%b, want bomb=%h reveal=%h cursor=%h game=%b busy=%b move=%b",
                             nm, act_s.bomb, act_s.reveal, act_s.cursor, act_s.game, act_s.bsy, act_s.mv,
                             exp_s.bomb, exp_s.reveal, exp_s.cursor, exp_s.game, exp_s.bsy, exp_s.mv);
                end
            end
        end
        if (move === 1'b1) begin
            move_width++;
        end else if (move_width != 0) begin
            tests++;
            if (move_width != 1) begin
                fails++;
                $display("FAIL move_width: got %0d cycles, want 1", move_width);
            end
            move_width = 0;
        end
    end

    task automatic expect_snap(input string name, input logic [N-1:0] b, input logic [N-1:0] r,
                               input logic [N-1:0] c, input logic [1:0] g, input logic bs,
                               input logic mv);
        snap_t s;
        s.bomb = b; s.reveal = r; s.cursor = c; s.game = g; s.bsy = bs; s.mv = mv;
        exp_q.push_back(s);
        name_q.push_back(name);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic aux_check(input string name, input int act, input int expv);
        aux_act_q.push_back(act);
        aux_exp_q.push_back(expv);
        aux_name_q.push_back(name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [N-1:0] b);
        bombIn = b; bombLoad = 1'b1;
        tick(1);
        bombLoad = 1'b0;
    endtask

    task automatic press_reveal();
        btnReveal = 1'b1;
        tick(1);
        btnReveal = 1'b0;
    endtask

    task automatic press_move(input logic [1:0] d);
        btnDir = d; btnMove = 1'b1;
        tick(1);
        btnMove = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; bombLoad = 1'b0; bombIn = '0; btnMove = 1'b0; btnDir = 2'b00; btnReveal = 1'b0;
        tick(3);
        reset = 1'b0;
        expect_snap("reset", 9'h000, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);

        // Bomb in bottom-right corner: reveal top-left floods everything else, then win.
        load(9'h001);
        expect_snap("load_001", 9'h001, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);
        press_reveal();
        wait_not_busy(40, n);
        aux_check("flood_busy_cycles", n, 4);
        tick(1);
        expect_snap("flood_win", 9'h001, 9'h1FE, 9'h100, GAME_WON, 1'b0, 1'b0);

        // Centre bomb: moves, board artefact, numbered reveals.
        load(9'h010);
        expect_snap("load_010", 9'h010, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);
        press_move(DIR_RIGHT);
        expect_snap("move_strobe", 9'h010, 9'h000, 9'h100, GAME_PLAY, 1'b1, 1'b1);
        tick(1);
        expect_snap("move_right", 9'h010, 9'h000, 9'h080, GAME_PLAY, 1'b0, 1'b0);
        press_reveal();
        wait_not_busy(40, n);
        aux_check("reveal_numbered_cycles", n, 1);
        expect_snap("reveal_numbered", 9'h010, 9'h080, 9'h080, GAME_PLAY, 1'b0, 1'b0);
        force_bad = 1'b1;
        press_move(DIR_DOWN);
        tick(1);
        force_bad = 1'b0;
        expect_snap("move_artefact", 9'h010, 9'h080, 9'h080, GAME_PLAY, 1'b0, 1'b0);
        press_move(DIR_DOWN);
        tick(1);
        press_move(DIR_LEFT);
        tick(1);
        expect_snap("move_down_left", 9'h010, 9'h080, 9'h020, GAME_PLAY, 1'b0, 1'b0);
        press_reveal();
        wait_not_busy(40, n);
        expect_snap("reveal_second", 9'h010, 9'h0A0, 9'h020, GAME_PLAY, 1'b0, 1'b0);

        // Bomb under the starting cursor.
        load(9'h100);
        expect_snap("load_100", 9'h100, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);
        press_reveal();
        wait_not_busy(40, n);
`ifdef MINE_FIRST_CLICK_SAFE_EN
        aux_check("first_click_cycles", n, 5);
        tick(1);
        expect_snap("first_click_safe", 9'h000, 9'h1FF, 9'h100, GAME_WON, 1'b0, 1'b0);
        press_move(DIR_RIGHT);
        press_reveal();
        tick(3);
        expect_snap("terminal_hold", 9'h000, 9'h1FF, 9'h100, GAME_WON, 1'b0, 1'b0);
`else
        aux_check("reveal_bomb_cycles", n, 1);
        expect_snap("reveal_bomb", 9'h100, 9'h100, 9'h100, GAME_LOST, 1'b0, 1'b0);
        press_move(DIR_RIGHT);
        press_reveal();
        tick(3);
        expect_snap("terminal_hold", 9'h100, 9'h100, 9'h100, GAME_LOST, 1'b0, 1'b0);
`endif

        // Moves into walls.
        load(9'h001);
        press_move(DIR_LEFT);
        expect_snap("wall_strobe", 9'h001, 9'h000, 9'h100, GAME_PLAY, 1'b1, 1'b1);
        tick(1);
        expect_snap("wall_left", 9'h001, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);
        press_move(DIR_UP);
        tick(1);
        expect_snap("wall_up", 9'h001, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);

        // Move during FLOOD is dropped.
        press_reveal();
        tick(1);
        press_move(DIR_RIGHT);
        wait_not_busy(40, n);
        tick(1);
        expect_snap("flood_ignores_move", 9'h001, 9'h1FE, 9'h100, GAME_WON, 1'b0, 1'b0);

        // bombLoad during FLOOD aborts it.
        load(9'h001);
        press_reveal();
        tick(1);
        load(9'h002);
        expect_snap("load_aborts_flood", 9'h002, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);
        tick(2);
        expect_snap("after_abort_idle", 9'h002, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);

        // reset during FLOOD.
        load(9'h001);
        press_reveal();
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_snap("reset_mid_flood", 9'h000, 9'h000, 9'h100, GAME_PLAY, 1'b0, 1'b0);

        // No bombs: whole grid floods.
        load(9'h000);
        press_reveal();
        wait_not_busy(40, n);
        aux_check("zero_bomb_cycles", n, 4);
        tick(1);
        expect_snap("zero_bomb_win", 9'h000, 9'h1FF, 9'h100, GAME_WON, 1'b0, 1'b0);

        // All bombs: already won with nothing revealed.
        load(9'h1FF);
        tick(1);
        expect_snap("all_bomb_win", 9'h1FF, 9'h000, 9'h100, GAME_WON, 1'b0, 1'b0);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule
